instruction_loader: RTL and testbench

// - Write side of the instruction store: receives a program image as a byte stream (UART receiver

---
 rtl/instruction_loader_pkg.sv | 14 +
 rtl/instruction_loader_word_packer.sv | 41 ++++
 rtl/instruction_loader.sv | 141 ++++++++++++++
 tb/tb_instruction_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and frame field widths.
package instruction_loader_pkg;
  localparam int HDR_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } ld_state_e;
endpackage

// File: rtl/instruction_loader_word_packer.sv
// Byte-to-word packer: keeps the three previous bytes and flags the 4th byte of each word.
module loader_word_packer
  import instruction_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [31:0]       word_next,
  output logic              word_last
);
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_vld) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The word is complete combinationally with the 4th byte; the top registers it.
  assign word_next = {shift_q, byte_in};
  assign word_last = byte_vld && !clr && (cnt_q == 2'd3);
endmodule

// File: rtl/instruction_loader.sv
// Receives a length-prefixed, XOR-checksummed program image byte stream and writes it
// word by word into instruction RAM, holding the CPU in reset until the image is verified.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] RxData,
  input  logic              RxValid,
  input  logic              Reload,
  output logic              MemWrite,
  output logic [31:0]       MemAddr,
  output logic [31:0]       MemWData,
  output logic              CpuReset_n,
  output logic              Loading,
  output logic              Error,
  output logic [ADDR_W:0]   WordCount
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [HDR_W:0] CAP = (HDR_W+1)'(1) << ADDR_W;

  ld_state_e         state_q, state_d;
  logic [BYTE_W-1:0] hdr_hi_q, hdr_hi_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              rx;
  logic              pk_vld;
  logic [31:0]       pk_word;
  logic              pk_last;
  logic [HDR_W-1:0]  n_hdr;
  logic              in_frame;

  assign rx       = RxValid && !Reload;
  assign pk_vld   = rx && (state_q == DATA);
  assign n_hdr    = {hdr_hi_q, RxData};
  assign in_frame = (state_q == HDR1) || (state_q == DATA) || (state_q == CHK);

  loader_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (Reload),
    .byte_vld  (pk_vld),
    .byte_in   (RxData),
    .word_next (pk_word),
    .word_last (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    hdr_hi_d = hdr_hi_q;
    wcnt_d   = wcnt_q;
    widx_d   = widx_q;
    xor_d    = xor_q;
    tmo_d    = tmo_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    if (Reload) begin
      state_d  = HDR0;
      hdr_hi_d = '0;
      wcnt_d   = '0;
      widx_d   = '0;
      xor_d    = '0;
      tmo_d    = '0;
    end else begin
      if (in_frame) tmo_d = rx ? '0 : tmo_q + TMO_W'(1);

      unique case (state_q)
        HDR0: if (rx) begin
          hdr_hi_d = RxData;
          state_d  = HDR1;
        end
        HDR1: if (rx) begin
          if ({1'b0, n_hdr} > CAP) begin
            state_d = ERROR;
          end else begin
            wcnt_d  = n_hdr[ADDR_W:0];
            state_d = (n_hdr == '0) ? CHK : DATA;
          end
        end
        DATA: if (rx) begin
          xor_d = xor_q ^ RxData;
          if (pk_last) begin
            we_d    = 1'b1;
            addr_d  = widx_q;
            wdata_d = pk_word;
            widx_d  = widx_q + ADDR_W'(1);
            if ({1'b0, widx_q} == wcnt_q - (ADDR_W+1)'(1)) state_d = CHK;
          end
        end
        CHK: if (rx) state_d = (RxData == xor_q) ? DONE : ERROR;
        default: ;
      endcase

      // A byte arriving on the last idle clock still counts as activity.
      if (in_frame && !rx && (tmo_q == TMO_W'(TIMEOUT - 1))) state_d = ERROR;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HDR0;
      hdr_hi_q <= '0;
      wcnt_q   <= '0;
      widx_q   <= '0;
      xor_q    <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      hdr_hi_q <= hdr_hi_d;
      wcnt_q   <= wcnt_d;
      widx_q   <= widx_d;
      xor_q    <= xor_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign MemWrite   = we_q;
  assign MemAddr    = {{(30-ADDR_W){1'b0}}, addr_q, 2'b00};
  assign MemWData   = wdata_q;
  assign CpuReset_n = (state_q == DONE);
  assign Loading    = in_frame;
  assign Error      = (state_q == ERROR);
  assign WordCount  = wcnt_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: expected RAM writes go to a scoreboard queue,
// a monitor pops and compares on every MemWrite; status outputs are checked inline.
module tb_instruction_loader;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  RxData = '0;
  logic        RxValid = 1'b0;
  logic        Reload = 1'b0;
  logic        MemWrite;
  logic [31:0] MemAddr, MemWData;
  logic        CpuReset_n, Loading, Error;
  logic [ADDR_W:0] WordCount;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  instruction_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .RxData(RxData), .RxValid(RxValid), .Reload(Reload),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
    .CpuReset_n(CpuReset_n), .Loading(Loading), .Error(Error), .WordCount(WordCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && MemWrite) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", MemAddr, MemWData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (MemAddr !== e.addr || MemWData !== e.data) begin
          miscompares++;
          $display("FAIL write: got 0x%08h/0x%08h expected 0x%08h/0x%08h",
                   MemAddr, MemWData, e.addr, e.data);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    RxData = b; RxValid = 1'b1;
    @(posedge clk); #1;
    RxValid = 1'b0;
  endtask

  task automatic reload();
    Reload = 1'b1;
    @(posedge clk); #1;
    Reload = 1'b0;
    chk("reload_error", {31'b0, Error}, 32'd0);
    chk("reload_cpurst", {31'b0, CpuReset_n}, 32'd0);
  endtask

  task automatic push_frame_writes(input int nwords);
    wr_t w[3];
    w[0] = '{32'h0, 32'h20040003};
    w[1] = '{32'h4, 32'h0C000003};
    w[2] = '{32'h8, 32'h1000FFFF};
    for (int i = 0; i < nwords; i++) exp_q.push_back(w[i]);
  endtask

  task automatic send_body(input int nbytes);
    logic [7:0] body[12];
    body = '{8'h20, 8'h04, 8'h00, 8'h03, 8'h0C, 8'h00, 8'h00, 8'h03,
             8'h10, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < nbytes; i++) send(body[i]);
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_cpurst", {31'b0, CpuReset_n}, 32'd0);
    chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("rst_loading", {31'b0, Loading}, 32'd0);
    chk("rst_error", {31'b0, Error}, 32'd0);
    chk("rst_wordcount", 32'(WordCount), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Normal load, bytes back-to-back.
    push_frame_writes(3);
    send(8'h00); send(8'h03);
    chk("norm_loading", {31'b0, Loading}, 32'd1);
    send_body(12);
    chk("norm_cpurst_pre", {31'b0, CpuReset_n}, 32'd0);
    send(8'h38);
    chk("norm_cpurst", {31'b0, CpuReset_n}, 32'd1);
    chk("norm_wordcount", 32'(WordCount), 32'd3);
    chk("norm_loading_off", {31'b0, Loading}, 32'd0);
    drain("norm_writes");
    chk("hold_addr", MemAddr, 32'h8);
    chk("hold_data", MemWData, 32'h1000FFFF);

    // Reload with a same-cycle byte while in DONE: byte must be dropped.
    Reload = 1'b1; RxValid = 1'b1; RxData = 8'h00;
    @(posedge clk); #1;
    Reload = 1'b0; RxValid = 1'b0;
    chk("rl_rx_cpurst", {31'b0, CpuReset_n}, 32'd0);
    chk("rl_rx_loading", {31'b0, Loading}, 32'd0);

    // Empty image.
    send(8'h00);
    chk("empty_hdr1", {31'b0, Loading}, 32'd1);
    send(8'h00); send(8'h00);
    chk("empty_done", {31'b0, CpuReset_n}, 32'd1);
    chk("empty_wordcount", 32'(WordCount), 32'd0);
    drain("empty_writes");

    // Bad checksum.
    reload();
    push_frame_writes(3);
    send(8'h00); send(8'h03);
    send_body(12);
    send(8'h39);
    chk("badchk_error", {31'b0, Error}, 32'd1);
    chk("badchk_cpurst", {31'b0, CpuReset_n}, 32'd0);
    send(8'h00);
    chk("error_sticky", {31'b0, Error}, 32'd1);
    drain("badchk_writes");

    // Oversize header: 257 words.
    reload();
    send(8'h01);
    chk("over_hdr1", {31'b0, Error}, 32'd0);
    send(8'h01);
    chk("over_error", {31'b0, Error}, 32'd1);
    drain("over_writes");

    // Timeout after 6 data bytes, then recover with a full frame.
    reload();
    push_frame_writes(1);
    send(8'h00); send(8'h03);
    send_body(6);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("tmo_not_yet", {31'b0, Error}, 32'd0);
    chk("tmo_loading", {31'b0, Loading}, 32'd1);
    @(posedge clk); #1;
    chk("tmo_error", {31'b0, Error}, 32'd1);
    drain("tmo_writes");
    reload();
    push_frame_writes(3);
    send(8'h00); send(8'h03);
    send_body(12);
    send(8'h38);
    chk("recover_done", {31'b0, CpuReset_n}, 32'd1);
    drain("recover_writes");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
